// File: rtl/mul_div_unit_pkg.sv
// Shared types and helpers for the RV32M multiply/divide unit.
//   mdu_op_t    : operation encoding in funct3 order (MUL=0 .. REMU=7)
//   mdu_state_t : control FSM states
//   MDU_ITERATIONS / MDU_COUNT_W : iteration count and counter width
//   op_* helpers: decode operation class and operand signedness
package mul_div_unit_pkg;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mdu_op_t;

    typedef enum logic [1:0] {
        MDU_IDLE,
        MDU_CALC,
        MDU_DONE
    } mdu_state_t;

    localparam int MDU_ITERATIONS = 32;
    localparam int MDU_COUNT_W    = $clog2(MDU_ITERATIONS);

    // Divide-class ops all have funct3[2] set.
    function automatic logic op_is_div(input mdu_op_t op);
        return op[2];
    endfunction

    function automatic logic op_is_rem(input mdu_op_t op);
        return op inside {MDU_REM, MDU_REMU};
    endfunction

    function automatic logic op_src1_signed(input mdu_op_t op);
        return op inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
    endfunction

    function automatic logic op_src2_signed(input mdu_op_t op);
        return op inside {MDU_MULH, MDU_DIV, MDU_REM};
    endfunction

endpackage

// File: rtl/div_mul_core.sv
// Radix-2 iterative datapath shared by multiply and divide.
// A single 64-bit register holds {high, low}:
//   multiply: {partial product high, remaining multiplier bits}
//   divide  : {partial remainder, dividend bits shifting into quotient}
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   start     : load operand magnitudes (op_a -> low half, op_b -> operand reg)
//   step      : perform one iteration
//   is_div    : selects restoring-divide step instead of shift-add
//   op_a/op_b : unsigned magnitudes (multiplier/dividend, multiplicand/divisor)
//   acc_next  : accumulator value after the current cycle's update, so the
//               caller can capture the final iteration's result on the same edge
module div_mul_core
    import mul_div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        step,
    input  logic        is_div,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [63:0] acc_next
);

    logic [63:0] acc;
    logic [31:0] operand;
    logic [32:0] mul_sum;
    logic [33:0] div_diff;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        acc_next = acc;
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);
        // Trial subtract of the divisor from the 33-bit shifted remainder;
        // bit 33 is the borrow.
        div_diff = {1'b0, acc[63:31]} - {2'b00, operand};
        if (start) begin
            acc_next = {32'd0, op_a};
        end else if (step) begin
            if (is_div) begin
                if (!div_diff[33]) acc_next = {div_diff[31:0], acc[30:0], 1'b1};
                else               acc_next = {acc[62:0], 1'b0};
            end else begin
                acc_next = {mul_sum, acc[31:1]};
            end
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            operand <= '0;
        end else begin
            acc <= acc_next;
            if (start) operand <= op_b;
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle RV32M multiply/divide unit beside the execute-stage ALU.
// Accepts one op per request handshake and returns one result per response
// handshake. Divide-by-zero and signed overflow complete without iterating.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   flush                 : abort any in-flight op (overrides both handshakes)
//   req_valid/req_ready   : request handshake (ready only in IDLE)
//   mdu_op, src1, src2    : operation and operands, sampled on acceptance only
//   resp_valid/resp_ready : response handshake (valid only in DONE)
//   result                : result word, stable while resp_valid
//   busy                  : high in CALC or DONE
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  mdu_op_t         mdu_op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    if (XLEN != 32) begin : g_bad_xlen
        $fatal(1, "mul_div_unit supports XLEN=32 only");
    end

    mdu_state_t             state;
    logic [MDU_COUNT_W-1:0] count;
    mdu_op_t                op_q;
    logic                   neg_q;
    logic                   neg_r;

    logic        sign1, sign2;
    logic [31:0] mag1, mag2;
    logic        special;
    logic [31:0] special_result;
    logic        accept;
    logic        core_start;
    logic [63:0] acc_next;
    logic [63:0] prod_signed;
    logic [31:0] final_result;

    // Operand preparation and early-out detection on the live request.
    always_comb begin
        sign1 = op_src1_signed(mdu_op) && src1[31];
        sign2 = op_src2_signed(mdu_op) && src2[31];
        mag1  = sign1 ? -src1 : src1;
        mag2  = sign2 ? -src2 : src2;

        special        = 1'b0;
        special_result = '0;
        if (op_is_div(mdu_op)) begin
            if (src2 == '0) begin
                special        = 1'b1;
                special_result = op_is_rem(mdu_op) ? src1 : '1;
            end else if (mdu_op inside {MDU_DIV, MDU_REM} &&
                         src1 == 32'h8000_0000 && src2 == '1) begin
                special        = 1'b1;
                special_result = op_is_rem(mdu_op) ? 32'd0 : 32'h8000_0000;
            end
        end
    end

    assign accept     = (state == MDU_IDLE) && req_valid && !flush;
    assign core_start = accept && !special;

    div_mul_core u_core (
        .clk      (clk),
        .rst      (rst),
        .start    (core_start),
        .step     (state == MDU_CALC),
        .is_div   (op_is_div(op_q)),
        .op_a     (mag1),
        .op_b     (mag2),
        .acc_next (acc_next)
    );

    // Sign post-processing of the value produced by the final iteration.
    always_comb begin
        prod_signed = neg_q ? -acc_next : acc_next;
        case (op_q)
            MDU_MULH, MDU_MULHSU, MDU_MULHU: final_result = prod_signed[63:32];
            MDU_DIV, MDU_DIVU: final_result = neg_q ? -acc_next[31:0]  : acc_next[31:0];
            MDU_REM, MDU_REMU: final_result = neg_r ? -acc_next[63:32] : acc_next[63:32];
            default:           final_result = prod_signed[31:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= MDU_IDLE;
            count      <= '0;
            op_q       <= MDU_MUL;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            result     <= '0;
        end else if (flush) begin
            state      <= MDU_IDLE;
            count      <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                MDU_IDLE: begin
                    if (accept) begin
                        op_q      <= mdu_op;
                        neg_q     <= sign1 ^ sign2;
                        neg_r     <= sign1;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        count     <= '0;
                        if (special) begin
                            state      <= MDU_DONE;
                            result     <= special_result;
                            resp_valid <= 1'b1;
                        end else begin
                            state <= MDU_CALC;
                        end
                    end
                end
                MDU_CALC: begin
                    count <= count + 1'b1;
                    if (count == MDU_COUNT_W'(MDU_ITERATIONS - 1)) begin
                        state      <= MDU_DONE;
                        result     <= final_result;
                        resp_valid <= 1'b1;
                    end
                end
                MDU_DONE: begin
                    if (resp_ready) begin
                        state      <= MDU_IDLE;
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: state <= MDU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    mdu_op_t     mdu_op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] result;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mul_div_unit #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .mdu_op     (mdu_op),
        .src1       (src1),
        .src2       (src2),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .result     (result),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " req_ready"},  32'(req_ready),  32'd1);
        check({tag, " resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, " busy"},       32'(busy),       32'd0);
    endtask

    // Issue one op from IDLE, measure latency, check result, optionally
    // hold off the response for 'hold' cycles, then retire it.
    task automatic do_op(input string tag, input mdu_op_t op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input int exp_lat, input int hold);
        int lat;
        logic [31:0] held;
        req_valid  = 1'b1;
        mdu_op     = op;
        src1       = a;
        src2       = b;
        resp_ready = (hold == 0);
        tick();
        // Operands are garbage after acceptance; the unit must ignore them.
        req_valid = 1'b0;
        src1      = $urandom;
        src2      = $urandom;
        mdu_op    = mdu_op_t'($urandom_range(0, 7));
        lat = 1;
        while (!resp_valid && lat < 60) begin
            tick();
            lat++;
        end
        check({tag, " latency"},   32'(lat), 32'(exp_lat));
        check({tag, " result"},    result, exp_res);
        check({tag, " req_ready"}, 32'(req_ready), 32'd0);
        check({tag, " busy"},      32'(busy), 32'd1);
        held = result;
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, " hold valid"}, 32'(resp_valid), 32'd1);
            check({tag, " hold result"}, result, held);
            check({tag, " hold req_ready"}, 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        tick();
        check_idle({tag, " retire"});
    endtask

    // Watch for a response that must never arrive.
    task automatic expect_silence(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (resp_valid) seen++;
        end
        check({tag, " no response"}, 32'(seen), 32'd0);
    endtask

    // Launch a normal op and let it run 'n' cycles past acceptance.
    task automatic launch(input mdu_op_t op, input logic [31:0] a, input logic [31:0] b,
                          input int n);
        req_valid  = 1'b1;
        mdu_op     = op;
        src1       = a;
        src2       = b;
        resp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        rst        = 1'b1;
        flush      = 1'b0;
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        mdu_op     = MDU_MUL;
        src1       = '0;
        src2       = '0;
        repeat (2) tick();
        check_idle("reset");
        check("reset result", result, 32'd0);
        rst = 1'b0;
        tick();

        // Multiply family: -2 * 3 = 0xFFFFFFFF_FFFFFFFA signed.
        do_op("mulh",   MDU_MULH,   32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFF, 33, 0);
        do_op("mul",    MDU_MUL,    32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFA, 33, 0);
        do_op("mulhu",  MDU_MULHU,  32'hFFFF_FFFE, 32'h3, 32'h0000_0002, 33, 0);
        do_op("mulhsu", MDU_MULHSU, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFF, 33, 0);
        do_op("mul0",   MDU_MUL,    32'h0,         32'h1234_5678, 32'h0, 33, 0);

        // Divide family.
        do_op("div",  MDU_DIV,  32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 33, 0);
        do_op("rem",  MDU_REM,  32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 33, 0);
        do_op("remn", MDU_REM,  32'h7, 32'hFFFF_FFFE, 32'h1, 33, 0);
        do_op("divu", MDU_DIVU, 32'd100, 32'd7, 32'd14, 33, 0);
        do_op("remu", MDU_REMU, 32'd100, 32'd7, 32'd2,  33, 0);

        // Early-out cases.
        do_op("divu0",  MDU_DIVU, 32'h0000_1234, 32'h0, 32'hFFFF_FFFF, 1, 0);
        do_op("rem0",   MDU_REM,  32'h1234_5678, 32'h0, 32'h1234_5678, 1, 0);
        do_op("divovf", MDU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        do_op("removf", MDU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 0);

        // Backpressure on the response.
        do_op("bp", MDU_DIVU, 32'd100, 32'd7, 32'd14, 33, 5);

        // Flush wins over a simultaneous request.
        req_valid = 1'b1;
        flush     = 1'b1;
        mdu_op    = MDU_DIVU;
        src1      = 32'd9;
        src2      = 32'd0;
        tick();
        req_valid = 1'b0;
        flush     = 1'b0;
        check_idle("flush vs req");
        expect_silence("flush vs req", 4);

        // Flush mid-CALC at iteration 10.
        launch(MDU_DIV, 32'h0000_0064, 32'h7, 10);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_idle("flush calc");
        do_op("after flush", MDU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0);

        // Reset mid-CALC: op discarded, reset values restored.
        launch(MDU_MUL, 32'h1234, 32'h5678, 10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("rst calc");
        check("rst calc result", result, 32'd0);
        expect_silence("rst calc", 40);
        do_op("after rst", MDU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
